hazard_controller: RTL and testbench

Pipeline hazard and stall sequencer for the five-stage MIPS core. It sits beside the main decode controller and drives the PC, IF/ID and ID/EX pipeline-register enables and flushes. It resolves load-use hazards, taken branches resolved in EX, ID-stage jumps and external memory wait-states. It remembers a branch redirect that arrives during a freeze so the redirect is not lost.

---
 rtl/hazard_controller.sv | 174 +++++++++++++++++
 tb/tb_hazard_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard and stall sequencer for the five-stage MIPS core
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRt,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Rt,
   input  logic             EX_BranchTaken,
   input  logic             ExtStall,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXBubble,
   output logic [1:0]       PCSrcSel,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FROZEN   = 2'd2
   } state_t;

   // Last bubble index; with a single bubble the LU_STALL state is never entered.
   localparam logic [2:0] LU_LAST  = 3'(LU_STALL_CYCLES - 1);
   localparam bit         LU_MULTI = (LU_STALL_CYCLES > 1);

   state_t     state, state_n;
   logic [2:0] lu_cnt, lu_cnt_n;
   logic       pend_branch, pend_branch_n;

   logic       lu_hit;
   logic       br_eff;
   logic       pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;
   logic [1:0] pc_src_c;

   // Hazard terms: register zero never creates a dependency; rt only matters when read.
   always_comb begin
      lu_hit = EX_MemRead && (EX_Rt != 5'd0) &&
               ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
      br_eff = EX_BranchTaken || pend_branch;
   end

   // Mealy output and next-state decode; a released freeze is decoded like RUN.
   always_comb begin
      pc_write_c    = 1'b1;
      ifid_write_c  = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
      pc_src_c      = 2'b00;
      state_n       = state;
      lu_cnt_n      = lu_cnt;
      pend_branch_n = pend_branch;

      case (state)
         LU_STALL: begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            if (!ExtStall) begin
               lu_cnt_n = lu_cnt + 3'd1;
               if (lu_cnt == LU_LAST) begin
                  state_n = RUN;
               end
            end
         end

         FROZEN: begin
            if (ExtStall) begin
               pc_write_c    = 1'b0;
               ifid_write_c  = 1'b0;
               pend_branch_n = pend_branch | EX_BranchTaken;
            end else begin
               state_n = RUN;
               if (br_eff) begin
                  pc_src_c      = 2'b01;
                  ifid_flush_c  = 1'b1;
                  idex_bubble_c = 1'b1;
                  pend_branch_n = 1'b0;
               end else if (lu_hit) begin
                  pc_write_c    = 1'b0;
                  ifid_write_c  = 1'b0;
                  idex_bubble_c = 1'b1;
                  lu_cnt_n      = 3'd1;
                  state_n       = LU_MULTI ? LU_STALL : RUN;
               end else if (ID_Jump) begin
                  pc_src_c     = 2'b10;
                  ifid_flush_c = 1'b1;
               end
            end
         end

         default: begin
            if (ExtStall) begin
               pc_write_c    = 1'b0;
               ifid_write_c  = 1'b0;
               pend_branch_n = br_eff;
               state_n       = FROZEN;
            end else if (br_eff) begin
               pc_src_c      = 2'b01;
               ifid_flush_c  = 1'b1;
               idex_bubble_c = 1'b1;
               pend_branch_n = 1'b0;
            end else if (lu_hit) begin
               pc_write_c    = 1'b0;
               ifid_write_c  = 1'b0;
               idex_bubble_c = 1'b1;
               lu_cnt_n      = 3'd1;
               state_n       = LU_MULTI ? LU_STALL : RUN;
            end else if (ID_Jump) begin
               pc_src_c     = 2'b10;
               ifid_flush_c = 1'b1;
            end
         end
      endcase
   end

   // Reset forces every pipeline enable low so nothing advances while held.
   always_comb begin
      PCWrite    = pc_write_c    & ~Rst;
      IFIDWrite  = ifid_write_c  & ~Rst;
      IFIDFlush  = ifid_flush_c  & ~Rst;
      IDEXBubble = idex_bubble_c & ~Rst;
      PCSrcSel   = Rst ? 2'b00 : pc_src_c;
   end

   // Sequencer state; reset drops any remembered redirect.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= RUN;
         lu_cnt      <= 3'd0;
         pend_branch <= 1'b0;
      end else begin
         state       <= state_n;
         lu_cnt      <= lu_cnt_n;
         pend_branch <= pend_branch_n;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Performance counters wrap naturally at their width.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write_c) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (ifid_flush_c) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   assign StallCnt = stall_cnt;
   assign FlushCnt = flush_cnt;
`else
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [4:0]  ID_Rs = '0;
   logic [4:0]  ID_Rt = '0;
   logic        ID_UsesRt = 1'b0;
   logic        ID_Jump = 1'b0;
   logic        EX_MemRead = 1'b0;
   logic [4:0]  EX_Rt = '0;
   logic        EX_BranchTaken = 1'b0;
   logic        ExtStall = 1'b0;

   logic        pcw1, ifidw1, flush1, bubble1;
   logic [1:0]  sel1;
   logic [31:0] stall1, fcnt1;
   logic        pcw3, ifidw3, flush3, bubble3;
   logic [1:0]  sel3;
   logic [31:0] stall3, fcnt3;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   hazard_controller #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut1 (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
      .EX_BranchTaken(EX_BranchTaken), .ExtStall(ExtStall),
      .PCWrite(pcw1), .IFIDWrite(ifidw1), .IFIDFlush(flush1), .IDEXBubble(bubble1),
      .PCSrcSel(sel1), .StallCnt(stall1), .FlushCnt(fcnt1)
   );

   hazard_controller #(.LU_STALL_CYCLES(3), .CNT_W(32)) dut3 (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
      .EX_BranchTaken(EX_BranchTaken), .ExtStall(ExtStall),
      .PCWrite(pcw3), .IFIDWrite(ifidw3), .IFIDFlush(flush3), .IDEXBubble(bubble3),
      .PCSrcSel(sel3), .StallCnt(stall3), .FlushCnt(fcnt3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] cnt(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic idle();
      ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
      EX_MemRead = 1'b0; EX_Rt = '0; EX_BranchTaken = 1'b0; ExtStall = 1'b0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      idle();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
   endtask

   int pcw_exp [6] = '{0, 0, 0, 0, 0, 1};
   int ext_seq [6] = '{0, 1, 1, 0, 0, 0};

   initial begin
      idle();
      Rst = 1'b1;
      #3;
      chk("rst_pcw",    64'(pcw1),   64'd0);
      chk("rst_ifidw",  64'(ifidw1), 64'd0);
      chk("rst_flush",  64'(flush1), 64'd0);
      chk("rst_bubble", 64'(bubble1),64'd0);
      chk("rst_sel",    64'(sel1),   64'd0);
      chk("rst_stall",  64'(stall1), 64'd0);
      chk("rst_fcnt",   64'(fcnt1),  64'd0);
      tick();
      Rst = 1'b0;
      settle();
      chk("idle_pcw",   64'(pcw1),   64'd1);
      chk("idle_ifidw", 64'(ifidw1), 64'd1);
      chk("idle_sel",   64'(sel1),   64'd0);

      // single-cycle load-use
      tick();
      EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
      settle();
      chk("lu_pcw",    64'(pcw1),   64'd0);
      chk("lu_ifidw",  64'(ifidw1), 64'd0);
      chk("lu_bubble", 64'(bubble1),64'd1);
      chk("lu_flush",  64'(flush1), 64'd0);
      tick();
      idle();
      settle();
      chk("lu_after_pcw",    64'(pcw1),   64'd1);
      chk("lu_after_bubble", 64'(bubble1),64'd0);
      chk("lu_stallcnt",     64'(stall1), 64'(cnt(1)));

      // register zero and unused rt
      EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
      settle();
      chk("r0_pcw", 64'(pcw1), 64'd1);
      EX_Rt = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
      settle();
      chk("rt_unused_pcw", 64'(pcw1), 64'd1);
      ID_UsesRt = 1'b1;
      settle();
      chk("rt_used_pcw",    64'(pcw1),    64'd0);
      chk("rt_used_bubble", 64'(bubble1), 64'd1);
      tick();
      idle();

      // branch beats load-use
      EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; EX_BranchTaken = 1'b1;
      settle();
      chk("br_lu_sel",    64'(sel1),    64'd1);
      chk("br_lu_flush",  64'(flush1),  64'd1);
      chk("br_lu_bubble", 64'(bubble1), 64'd1);
      chk("br_lu_pcw",    64'(pcw1),    64'd1);
      tick();
      idle();
      settle();
      chk("br_fcnt",  64'(fcnt1),  64'(cnt(1)));
      chk("br_stall", 64'(stall1), 64'(cnt(2)));

      // jump alone, then branch with jump
      ID_Jump = 1'b1;
      settle();
      chk("j_sel",    64'(sel1),    64'd2);
      chk("j_flush",  64'(flush1),  64'd1);
      chk("j_bubble", 64'(bubble1), 64'd0);
      chk("j_pcw",    64'(pcw1),    64'd1);
      tick();
      EX_BranchTaken = 1'b1;
      settle();
      chk("brj_sel", 64'(sel1), 64'd1);
      tick();
      idle();
      settle();
      chk("j_after_sel", 64'(sel1),  64'd0);
      chk("j_fcnt",      64'(fcnt1), 64'(cnt(3)));

      // branch pulse during a 3-cycle freeze
      do_reset();
      ExtStall = 1'b1; EX_BranchTaken = 1'b1;
      settle();
      chk("fz1_pcw",   64'(pcw1),   64'd0);
      chk("fz1_ifidw", 64'(ifidw1), 64'd0);
      chk("fz1_flush", 64'(flush1), 64'd0);
      chk("fz1_sel",   64'(sel1),   64'd0);
      tick();
      EX_BranchTaken = 1'b0;
      settle();
      chk("fz2_pcw", 64'(pcw1), 64'd0);
      chk("fz2_sel", 64'(sel1), 64'd0);
      tick();
      settle();
      chk("fz3_pcw", 64'(pcw1), 64'd0);
      tick();
      ExtStall = 1'b0;
      settle();
      chk("fz4_pcw",    64'(pcw1),    64'd1);
      chk("fz4_sel",    64'(sel1),    64'd1);
      chk("fz4_flush",  64'(flush1),  64'd1);
      chk("fz4_bubble", 64'(bubble1), 64'd1);
      tick();
      settle();
      chk("fz5_sel",   64'(sel1),   64'd0);
      chk("fz5_flush", 64'(flush1), 64'd0);
      chk("fz_stall",  64'(stall1), 64'(cnt(3)));
      chk("fz_fcnt",   64'(fcnt1),  64'(cnt(1)));

      // three-bubble load-use stretched by a 2-cycle freeze
      do_reset();
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c == 0) begin
            EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
         end
         ExtStall = ext_seq[c][0];
         if (c == 3) EX_BranchTaken = 1'b1;
         settle();
         chk($sformatf("mlu_pcw_c%0d", c), 64'(pcw3), 64'(pcw_exp[c]));
         if (c < 5) begin
            chk($sformatf("mlu_bubble_c%0d", c), 64'(bubble3), 64'd1);
            chk($sformatf("mlu_sel_c%0d", c),    64'(sel3),    64'd0);
         end
         tick();
      end
      idle();
      settle();
      chk("mlu_stall", 64'(stall3), 64'(cnt(5)));

      // reset mid-stall on the three-bubble instance
      do_reset();
      EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
      tick();
      idle();
      ExtStall = 1'b1;
      tick();
      Rst = 1'b1;
      settle();
      chk("mrst_pcw",    64'(pcw3),    64'd0);
      chk("mrst_bubble", 64'(bubble3), 64'd0);
      chk("mrst_sel",    64'(sel3),    64'd0);
      chk("mrst_stall",  64'(stall3),  64'd0);
      chk("mrst_fcnt",   64'(fcnt3),   64'd0);
      idle();
      tick();
      Rst = 1'b0;
      settle();
      chk("mrst_after_pcw",    64'(pcw3),    64'd1);
      chk("mrst_after_bubble", 64'(bubble3), 64'd0);

      // reset mid-freeze drops the remembered branch
      do_reset();
      ExtStall = 1'b1; EX_BranchTaken = 1'b1;
      tick();
      EX_BranchTaken = 1'b0;
      Rst = 1'b1;
      tick();
      idle();
      Rst = 1'b0;
      settle();
      chk("frst_sel",   64'(sel1),   64'd0);
      chk("frst_flush", 64'(flush1), 64'd0);
      chk("frst_pcw",   64'(pcw1),   64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
